// File: rtl/risc_spm_pkg.sv
// Shared definitions for the 8-bit processing unit sequencer:
// opcodes, FSM states, bus select codes and error codes.
package risc_spm_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_NOT  = 4'h4;
   localparam logic [3:0] OP_RD   = 4'h5;
   localparam logic [3:0] OP_WR   = 4'h6;
   localparam logic [3:0] OP_BR   = 4'h7;
   localparam logic [3:0] OP_BRZ  = 4'h8;
   localparam logic [3:0] OP_BROV = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FET1,
      S_FET2,
      S_DEC,
      S_EX1,
      S_RD1,
      S_RD2,
      S_WR1,
      S_WR2,
      S_BR1,
      S_BR2,
      S_MUL_WAIT,
      S_MUL_LO,
      S_MUL_HI,
      S_HALT
   } state_t;

   localparam logic [2:0] SEL1_PC     = 3'd4;

   localparam logic [2:0] SEL2_ALU    = 3'd0;
   localparam logic [2:0] SEL2_BUS1   = 3'd1;
   localparam logic [2:0] SEL2_MEM    = 3'd2;
   localparam logic [2:0] SEL2_MUL_LO = 3'd3;
   localparam logic [2:0] SEL2_MUL_HI = 3'd4;

   localparam logic [1:0] ERR_NONE        = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL     = 2'd1;
   localparam logic [1:0] ERR_MUL_TIMEOUT = 2'd2;

endpackage

// File: rtl/reg_load_decode.sv
// Turns a 2-bit register index plus enable into one-hot register load strobes.
module reg_load_decode (
   input  logic       en,
   input  logic [1:0] idx,
   output logic [3:0] load_r
);

   always_comb begin
      load_r = 4'b0000;
      if (en) load_r[idx] = 1'b1;
   end

endmodule

// File: rtl/risc_control_unit.sv
// Moore sequencer for the 8-bit processing unit: fetch/decode/execute,
// bus mux selects, register/flag load strobes and the multiply handshake.
//
// state      | meaning
// S_IDLE     | waiting for run
// S_FET1     | PC -> address register
// S_FET2     | memory -> IR, PC++
// S_DEC      | decode opcode, first operand step
// S_EX1      | ALU result -> dest, flags
// S_RD1/RD2  | fetch operand address, memory -> dest
// S_WR1/WR2  | fetch operand address, src -> memory
// S_BR1/BR2  | fetch branch target, target -> PC
// S_MUL_WAIT | wait for registered multiply-done, bounded by MUL_TIMEOUT
// S_MUL_LO   | product LSB -> dest
// S_MUL_HI   | product MSB -> src
// S_HALT     | stopped until rst
module risc_control_unit
   import risc_spm_pkg::*;
#(
   parameter int word_size   = 8,
   parameter int op_size     = 4,
   parameter int Sel1_size   = 3,
   parameter int Sel2_size   = 3,
   parameter int MUL_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [word_size-1:0] instruction,
   input  logic                 Zflag,
   input  logic                 ovflag,
   input  logic                 mdflag,
   output logic                 Load_R0,
   output logic                 Load_R1,
   output logic                 Load_R2,
   output logic                 Load_R3,
   output logic                 Load_PC,
   output logic                 Inc_PC,
   output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
   output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
   output logic                 Load_IR,
   output logic                 Load_Add_R,
   output logic                 Load_Reg_Y,
   output logic                 Load_Reg_Z,
   output logic                 Load_Reg_ov,
   output logic                 Load_Reg_md,
   output logic                 write,
   output logic                 halted,
   output logic [1:0]           err
);

   localparam int CNT_W = $clog2(MUL_TIMEOUT) + 1;

   state_t           state, state_next;
   logic [CNT_W-1:0] mul_cnt;
   logic             mul_clr, mul_inc;
   logic [1:0]       err_next;
   logic             load_r_en;
   logic [1:0]       load_r_idx;
   logic [3:0]       load_r;

   logic [op_size-1:0] opcode;
   logic [1:0]         src, dest;

   assign opcode = instruction[word_size-1 -: op_size];
   assign src    = instruction[3:2];
   assign dest   = instruction[1:0];

   always_comb begin
      state_next    = state;
      mul_clr       = 1'b0;
      mul_inc       = 1'b0;
      err_next      = err;
      load_r_en     = 1'b0;
      load_r_idx    = dest;
      Load_PC       = 1'b0;
      Inc_PC        = 1'b0;
      Sel_Bus_1_Mux = '0;
      Sel_Bus_2_Mux = '0;
      Load_IR       = 1'b0;
      Load_Add_R    = 1'b0;
      Load_Reg_Y    = 1'b0;
      Load_Reg_Z    = 1'b0;
      Load_Reg_ov   = 1'b0;
      Load_Reg_md   = 1'b0;
      write         = 1'b0;

      case (state)
         S_IDLE: if (run) state_next = S_FET1;
         S_FET1: begin
            Sel_Bus_1_Mux = Sel1_size'(SEL1_PC);
            Sel_Bus_2_Mux = Sel2_size'(SEL2_BUS1);
            Load_Add_R    = 1'b1;
            state_next    = S_FET2;
         end
         S_FET2: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MEM);
            Load_IR       = 1'b1;
            Inc_PC        = 1'b1;
            state_next    = S_DEC;
         end
         S_DEC: begin
            case (opcode)
               OP_NOP: state_next = S_FET1;
               OP_ADD, OP_SUB, OP_AND: begin
                  Sel_Bus_1_Mux = Sel1_size'(src);
                  Sel_Bus_2_Mux = Sel2_size'(SEL2_BUS1);
                  Load_Reg_Y    = 1'b1;
                  state_next    = S_EX1;
               end
               OP_NOT: state_next = S_EX1;
               OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BROV: begin
                  // A conditional branch not taken just skips its operand word.
                  if ((opcode == OP_BRZ && !Zflag) || (opcode == OP_BROV && !ovflag)) begin
                     Inc_PC     = 1'b1;
                     state_next = S_FET1;
                  end else begin
                     Sel_Bus_1_Mux = Sel1_size'(SEL1_PC);
                     Sel_Bus_2_Mux = Sel2_size'(SEL2_BUS1);
                     Load_Add_R    = 1'b1;
                     if (opcode == OP_RD)      state_next = S_RD1;
                     else if (opcode == OP_WR) state_next = S_WR1;
                     else                      state_next = S_BR1;
                  end
               end
               OP_MUL: begin
                  Sel_Bus_1_Mux = Sel1_size'(src);
                  Sel_Bus_2_Mux = Sel2_size'(SEL2_BUS1);
                  Load_Reg_Y    = 1'b1;
                  mul_clr       = 1'b1;
                  state_next    = S_MUL_WAIT;
               end
               OP_HALT: state_next = S_HALT;
               default: begin
                  err_next   = ERR_ILLEGAL;
                  state_next = S_HALT;
               end
            endcase
         end
         S_EX1: begin
            Sel_Bus_1_Mux = (opcode == OP_NOT) ? Sel1_size'(src) : Sel1_size'(dest);
            Sel_Bus_2_Mux = Sel2_size'(SEL2_ALU);
            load_r_en     = 1'b1;
            Load_Reg_Z    = 1'b1;
            Load_Reg_ov   = (opcode == OP_ADD) || (opcode == OP_SUB);
            state_next    = S_FET1;
         end
         S_RD1, S_WR1: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MEM);
            Load_Add_R    = 1'b1;
            Inc_PC        = 1'b1;
            state_next    = (state == S_RD1) ? S_RD2 : S_WR2;
         end
         S_RD2: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MEM);
            load_r_en     = 1'b1;
            state_next    = S_FET1;
         end
         S_WR2: begin
            Sel_Bus_1_Mux = Sel1_size'(src);
            write         = 1'b1;
            state_next    = S_FET1;
         end
         S_BR1: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MEM);
            Load_Add_R    = 1'b1;
            state_next    = S_BR2;
         end
         S_BR2: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MEM);
            Load_PC       = 1'b1;
            state_next    = S_FET1;
         end
         S_MUL_WAIT: begin
            Sel_Bus_1_Mux = Sel1_size'(dest);
            Load_Reg_md   = 1'b1;
            mul_inc       = 1'b1;
            if (mdflag) begin
               state_next = S_MUL_LO;
            end else if (mul_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
               err_next   = ERR_MUL_TIMEOUT;
               state_next = S_HALT;
            end
         end
         S_MUL_LO: begin
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MUL_LO);
            load_r_en     = 1'b1;
            state_next    = S_MUL_HI;
         end
         S_MUL_HI: begin
            // With src == dest the MSB simply overwrites the LSB.
            Sel_Bus_2_Mux = Sel2_size'(SEL2_MUL_HI);
            load_r_en     = 1'b1;
            load_r_idx    = src;
            Load_Reg_ov   = 1'b1;
            state_next    = S_FET1;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         mul_cnt <= '0;
         halted  <= 1'b0;
         err     <= ERR_NONE;
      end else begin
         state  <= state_next;
         halted <= (state_next == S_HALT);
         err    <= err_next;
         if (mul_clr)      mul_cnt <= '0;
         else if (mul_inc) mul_cnt <= mul_cnt + 1'b1;
      end
   end

   reg_load_decode u_reg_load_decode (
      .en     (load_r_en),
      .idx    (load_r_idx),
      .load_r (load_r)
   );

   assign {Load_R3, Load_R2, Load_R1, Load_R0} = load_r;

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: expected per-cycle output vectors are
// queued as inputs are driven and compared one cycle later.
module tb_risc_control_unit;

   typedef struct packed {
      logic [3:0] ld_r;
      logic       ld_pc;
      logic       inc_pc;
      logic [2:0] s1;
      logic [2:0] s2;
      logic       ld_ir;
      logic       ld_ar;
      logic       ld_y;
      logic       ld_z;
      logic       ld_ov;
      logic       ld_md;
      logic       wr;
      logic       hlt;
      logic [1:0] er;
   } o_t;

   logic       clk = 1'b0;
   logic       rst, run, Zflag, ovflag, mdflag;
   logic [7:0] instruction;
   logic       Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC;
   logic [2:0] Sel_Bus_1_Mux, Sel_Bus_2_Mux;
   logic       Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md;
   logic       write, halted;
   logic [1:0] err;

   o_t    exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 clk = ~clk;

   risc_control_unit dut (
      .clk(clk), .rst(rst), .run(run), .instruction(instruction),
      .Zflag(Zflag), .ovflag(ovflag), .mdflag(mdflag),
      .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
      .Load_PC(Load_PC), .Inc_PC(Inc_PC),
      .Sel_Bus_1_Mux(Sel_Bus_1_Mux), .Sel_Bus_2_Mux(Sel_Bus_2_Mux),
      .Load_IR(Load_IR), .Load_Add_R(Load_Add_R), .Load_Reg_Y(Load_Reg_Y),
      .Load_Reg_Z(Load_Reg_Z), .Load_Reg_ov(Load_Reg_ov), .Load_Reg_md(Load_Reg_md),
      .write(write), .halted(halted), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, want);
   endtask

   function automatic o_t o_z();
      o_t o = '0;
      return o;
   endfunction
   function automatic o_t o_fet1();
      o_t o = '0; o.s1 = 3'd4; o.s2 = 3'd1; o.ld_ar = 1'b1; return o;
   endfunction
   function automatic o_t o_fet2();
      o_t o = '0; o.s2 = 3'd2; o.ld_ir = 1'b1; o.inc_pc = 1'b1; return o;
   endfunction
   function automatic o_t o_dec_alu(input logic [1:0] src);
      o_t o = '0; o.s1 = {1'b0, src}; o.s2 = 3'd1; o.ld_y = 1'b1; return o;
   endfunction
   function automatic o_t o_ex1(input logic [1:0] sel, input logic [1:0] dest, input logic ov);
      o_t o = '0;
      o.s1 = {1'b0, sel}; o.ld_r = 4'(1) << dest; o.ld_z = 1'b1; o.ld_ov = ov;
      return o;
   endfunction
   function automatic o_t o_inc();
      o_t o = '0; o.inc_pc = 1'b1; return o;
   endfunction
   function automatic o_t o_opnd1();
      o_t o = '0; o.s2 = 3'd2; o.ld_ar = 1'b1; o.inc_pc = 1'b1; return o;
   endfunction
   function automatic o_t o_rd2(input logic [1:0] dest);
      o_t o = '0; o.s2 = 3'd2; o.ld_r = 4'(1) << dest; return o;
   endfunction
   function automatic o_t o_wr2(input logic [1:0] src);
      o_t o = '0; o.s1 = {1'b0, src}; o.wr = 1'b1; return o;
   endfunction
   function automatic o_t o_br1();
      o_t o = '0; o.s2 = 3'd2; o.ld_ar = 1'b1; return o;
   endfunction
   function automatic o_t o_br2();
      o_t o = '0; o.s2 = 3'd2; o.ld_pc = 1'b1; return o;
   endfunction
   function automatic o_t o_wait(input logic [1:0] dest);
      o_t o = '0; o.s1 = {1'b0, dest}; o.ld_md = 1'b1; return o;
   endfunction
   function automatic o_t o_lo(input logic [1:0] dest);
      o_t o = '0; o.s2 = 3'd3; o.ld_r = 4'(1) << dest; return o;
   endfunction
   function automatic o_t o_hi(input logic [1:0] src);
      o_t o = '0; o.s2 = 3'd4; o.ld_r = 4'(1) << src; o.ld_ov = 1'b1; return o;
   endfunction
   function automatic o_t o_halt(input logic [1:0] er);
      o_t o = '0; o.hlt = 1'b1; o.er = er; return o;
   endfunction

   // Called at a falling edge with inputs already set; e is what the outputs
   // must show after the next rising edge.
   task automatic step(input o_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      o_t    a, e;
      string t;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC, Sel_Bus_1_Mux,
              Sel_Bus_2_Mux, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_Reg_ov,
              Load_Reg_md, write, halted, err};
         chk(t, 32'(a), 32'(e));
      end
   end

   initial begin
      rst = 1'b1; run = 1'b0; Zflag = 1'b0; ovflag = 1'b0; mdflag = 1'b0;
      instruction = 8'h00;
      @(negedge clk);
      step(o_z(), "reset0");
      step(o_z(), "reset1");
      rst = 1'b0;
      step(o_z(), "idle_no_run");
      run = 1'b1;
      step(o_fet1(), "start_fet1");

      instruction = 8'h16;
      step(o_fet2(), "add_fet2");
      step(o_dec_alu(2'd1), "add_dec");
      step(o_ex1(2'd2, 2'd2, 1'b1), "add_ex1");
      step(o_fet1(), "add_fet1");

      instruction = 8'h33;
      step(o_fet2(), "and_fet2");
      step(o_dec_alu(2'd0), "and_dec");
      step(o_ex1(2'd3, 2'd3, 1'b0), "and_ex1");
      step(o_fet1(), "and_fet1");

      instruction = 8'h49;
      step(o_fet2(), "not_fet2");
      step(o_z(), "not_dec");
      step(o_ex1(2'd2, 2'd1, 1'b0), "not_ex1");
      step(o_fet1(), "not_fet1");

      instruction = 8'h00;
      step(o_fet2(), "nop_fet2");
      step(o_z(), "nop_dec");
      step(o_fet1(), "nop_fet1");

      instruction = 8'h80; Zflag = 1'b0;
      step(o_fet2(), "brz0_fet2");
      step(o_inc(), "brz0_dec");
      step(o_fet1(), "brz0_fet1");

      Zflag = 1'b1;
      step(o_fet2(), "brz1_fet2");
      step(o_fet1(), "brz1_dec");
      step(o_br1(), "brz1_br1");
      step(o_br2(), "brz1_br2");
      step(o_fet1(), "brz1_fet1");

      instruction = 8'h90; Zflag = 1'b0; ovflag = 1'b0;
      step(o_fet2(), "brov0_fet2");
      step(o_inc(), "brov0_dec");
      step(o_fet1(), "brov0_fet1");
      ovflag = 1'b1;
      step(o_fet2(), "brov1_fet2");
      step(o_fet1(), "brov1_dec");
      step(o_br1(), "brov1_br1");
      step(o_br2(), "brov1_br2");
      step(o_fet1(), "brov1_fet1");
      ovflag = 1'b0;

      instruction = 8'h52;
      step(o_fet2(), "rd_fet2");
      step(o_fet1(), "rd_dec");
      step(o_opnd1(), "rd_rd1");
      step(o_rd2(2'd2), "rd_rd2");
      step(o_fet1(), "rd_fet1");

      instruction = 8'h6C;
      step(o_fet2(), "wr_fet2");
      step(o_fet1(), "wr_dec");
      step(o_opnd1(), "wr_wr1");
      step(o_wr2(2'd3), "wr_wr2");
      step(o_fet1(), "wr_fet1");

      instruction = 8'hA6;
      step(o_fet2(), "mul_fet2");
      step(o_dec_alu(2'd1), "mul_dec");
      step(o_wait(2'd2), "mul_wait1");
      step(o_wait(2'd2), "mul_wait2");
      step(o_wait(2'd2), "mul_wait3");
      mdflag = 1'b1;
      step(o_lo(2'd2), "mul_lo");
      mdflag = 1'b0;
      step(o_hi(2'd1), "mul_hi");
      step(o_fet1(), "mul_fet1");

      step(o_fet2(), "mulrst_fet2");
      step(o_dec_alu(2'd1), "mulrst_dec");
      step(o_wait(2'd2), "mulrst_wait1");
      step(o_wait(2'd2), "mulrst_wait2");
      rst = 1'b1;
      step(o_z(), "mulrst_idle");
      rst = 1'b0; run = 1'b0;
      step(o_z(), "mulrst_stay");
      run = 1'b1;
      step(o_fet1(), "to_fet1");
      step(o_fet2(), "multo_fet2");
      step(o_dec_alu(2'd1), "multo_dec");
      for (int i = 0; i < 16; i++) step(o_wait(2'd2), $sformatf("multo_wait%0d", i + 1));
      step(o_halt(2'd2), "multo_halt");
      run = 1'b0;
      step(o_halt(2'd2), "multo_hold");
      rst = 1'b1;
      step(o_z(), "multo_rst");

      rst = 1'b0; run = 1'b1; instruction = 8'hB0;
      step(o_fet1(), "ill_fet1");
      step(o_fet2(), "ill_fet2");
      step(o_z(), "ill_dec");
      step(o_halt(2'd1), "ill_halt");
      step(o_halt(2'd1), "ill_hold");
      rst = 1'b1;
      step(o_z(), "ill_rst");

      rst = 1'b0; instruction = 8'hF0;
      step(o_fet1(), "hlt_fet1");
      step(o_fet2(), "hlt_fet2");
      step(o_z(), "hlt_dec");
      step(o_halt(2'd0), "hlt_halt");
      step(o_halt(2'd0), "hlt_hold");

      @(posedge clk);
      #2;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
